udp_tx_framer: RTL and testbench

- TX-path consumer of the UDP offload engine control registers (fpga/host MAC, IP and UDP port, payload_per_packet, checksum_ip, tx_rst).
- Segments a continuous 64-bit kernel payload stream into UDP/IPv4/Ethernet frames.
- Prepends a 42-byte header to each frame and drives an AXI-Stream source toward the Ethernet MAC.
- Sits directly downstream of the CSR block, on the TX side of the channel.

---
 rtl/udp_tx_framer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: cuts a 64-bit payload stream into UDP/IPv4/Ethernet frames.
// Define UDP_TX_IP_CSUM_EN to compute the IPv4 header checksum in hardware.
module udp_tx_framer #(
   parameter int unsigned MAX_PAYLOAD = 1472,
   parameter logic [7:0]  IP_TTL      = 8'h40,
   parameter int unsigned PKT_CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_rst,
   input  logic [47:0]          fpga_mac_adr,
   input  logic [47:0]          host_mac_adr,
   input  logic [31:0]          fpga_ip_adr,
   input  logic [31:0]          host_ip_adr,
   input  logic [15:0]          fpga_udp_port,
   input  logic [15:0]          host_udp_port,
   input  logic [15:0]          payload_per_packet,
   input  logic [15:0]          checksum_ip,
   input  logic [63:0]          s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   output logic [63:0]          m_tdata,
   output logic [7:0]           m_tkeep,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 m_tlast,
   output logic                 cfg_err,
   output logic [PKT_CNT_W-1:0] pkt_count
);

`ifdef UDP_TX_IP_CSUM_EN
   typedef enum logic [2:0] {IDLE, CALC, HDR, BODY, TAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;
`endif

   state_t               state_q, state_d;
   logic [2:0]           hidx_q, hidx_d;
   logic [12:0]          wcnt_q, wcnt_d;
   logic [15:0]          carry_q, carry_d;
   logic [15:0]          ip_id_q, ip_id_d;
   logic [47:0]          dmac_q, dmac_d, smac_q, smac_d;
   logic [31:0]          sip_q, sip_d, dip_q, dip_d;
   logic [15:0]          sport_q, sport_d, dport_q, dport_d;
   logic [15:0]          plen_q, plen_d;
   logic [15:0]          csum_q, csum_d;
   logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
   logic                 cfg_err_q, cfg_err_d;
   logic [63:0]          tdata_q, tdata_d;
   logic [7:0]           tkeep_q, tkeep_d;
   logic                 tvalid_q, tvalid_d;
   logic                 tlast_q, tlast_d;
   logic                 s_ready;
   logic                 legal, adv;
   logic [12:0]          n_words;
   logic [15:0]          ip_len, udp_len;
   logic [63:0]          hdr;
`ifdef UDP_TX_IP_CSUM_EN
   logic [19:0]          sum_q, sum_d;
   logic                 calc_q, calc_d;
   logic [16:0]          fold1;
   logic [15:0]          fold2;
   logic                 unused_csum;
   assign unused_csum = ^checksum_ip;
`else
   logic [63:0]          b0_in;
`endif

   // Big-endian field concatenation -> first wire byte in [7:0]
   function automatic logic [63:0] wire_order(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
      return r;
   endfunction

   assign legal   = (payload_per_packet != 16'd0) &&
                    (payload_per_packet[2:0] == 3'd0) &&
                    (payload_per_packet <= 16'(MAX_PAYLOAD));
   assign n_words = plen_q[15:3];
   assign ip_len  = plen_q + 16'd28;
   assign udp_len = plen_q + 16'd8;
   assign adv     = !tvalid_q || m_tready;
`ifdef UDP_TX_IP_CSUM_EN
   assign fold1   = {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
   assign fold2   = fold1[15:0] + {15'h0, fold1[16]};
`else
   assign b0_in   = wire_order({host_mac_adr, fpga_mac_adr[47:32]});
`endif

   // Header beat selected by index, built from the snapshotted config
   always_comb begin
      hdr = '0;
      case (hidx_q)
         3'd0: hdr = wire_order({dmac_q, smac_q[47:32]});
         3'd1: hdr = wire_order({smac_q[31:0], 16'h0800, 16'h4500});
         3'd2: hdr = wire_order({ip_len, ip_id_q, 16'h4000, IP_TTL, 8'h11});
         3'd3: hdr = wire_order({csum_q, sip_q, dip_q[31:16]});
         3'd4: hdr = wire_order({dip_q[15:0], sport_q, dport_q, udp_len});
         default: hdr = '0;
      endcase
   end

   // Framing FSM: next state, output register load and input accept
   always_comb begin
      state_d   = state_q;
      hidx_d    = hidx_q;
      wcnt_d    = wcnt_q;
      carry_d   = carry_q;
      ip_id_d   = ip_id_q;
      dmac_d    = dmac_q;
      smac_d    = smac_q;
      sip_d     = sip_q;
      dip_d     = dip_q;
      sport_d   = sport_q;
      dport_d   = dport_q;
      plen_d    = plen_q;
      csum_d    = csum_q;
      pkt_d     = pkt_q;
      cfg_err_d = cfg_err_q;
      tdata_d   = tdata_q;
      tkeep_d   = tkeep_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      s_ready   = 1'b0;
`ifdef UDP_TX_IP_CSUM_EN
      sum_d     = sum_q;
      calc_d    = calc_q;
`endif
      // a presented beat that is accepted leaves the register empty
      if (tvalid_q && m_tready) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (s_tvalid) begin
               if (!legal) begin
                  cfg_err_d = 1'b1;
               end else begin
                  dmac_d  = host_mac_adr;
                  smac_d  = fpga_mac_adr;
                  sip_d   = fpga_ip_adr;
                  dip_d   = host_ip_adr;
                  sport_d = fpga_udp_port;
                  dport_d = host_udp_port;
                  plen_d  = payload_per_packet;
                  wcnt_d  = '0;
                  carry_d = '0;
`ifdef UDP_TX_IP_CSUM_EN
                  hidx_d  = 3'd0;
                  calc_d  = 1'b0;
                  state_d = CALC;
`else
                  csum_d   = checksum_ip;
                  tdata_d  = b0_in;
                  tkeep_d  = 8'hFF;
                  tvalid_d = 1'b1;
                  hidx_d   = 3'd1;
                  state_d  = HDR;
`endif
               end
            end
         end
`ifdef UDP_TX_IP_CSUM_EN
         CALC: begin
            if (!calc_q) begin
               sum_d = 20'h04500 + {4'h0, ip_len} + {4'h0, ip_id_q} +
                       20'h04000 + {4'h0, IP_TTL, 8'h11} +
                       {4'h0, sip_q[31:16]} + {4'h0, sip_q[15:0]} +
                       {4'h0, dip_q[31:16]} + {4'h0, dip_q[15:0]};
               calc_d = 1'b1;
            end else begin
               csum_d   = ~fold2;
               tdata_d  = hdr;
               tkeep_d  = 8'hFF;
               tvalid_d = 1'b1;
               hidx_d   = 3'd1;
               state_d  = HDR;
            end
         end
`endif
         HDR: begin
            if (adv) begin
               tdata_d  = hdr;
               tkeep_d  = 8'hFF;
               tvalid_d = 1'b1;
               hidx_d   = hidx_q + 3'd1;
               if (hidx_q == 3'd4) state_d = BODY;
            end
         end
         BODY: begin
            s_ready = adv;
            if (adv && s_tvalid) begin
               tdata_d  = {s_tdata[47:0], carry_q};
               tkeep_d  = 8'hFF;
               tvalid_d = 1'b1;
               carry_d  = s_tdata[63:48];
               wcnt_d   = wcnt_q + 13'd1;
               if (wcnt_q == n_words - 13'd1) state_d = TAIL;
            end
         end
         TAIL: begin
            if (tlast_q) begin
               if (m_tready) begin
                  pkt_d   = pkt_q + PKT_CNT_W'(1);
                  ip_id_d = ip_id_q + 16'd1;
                  state_d = IDLE;
               end
            end else if (adv) begin
               tdata_d  = {48'h0, carry_q};
               tkeep_d  = 8'h03;
               tvalid_d = 1'b1;
               tlast_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // soft reset abandons any frame in flight
      if (tx_rst) begin
         state_d   = IDLE;
         hidx_d    = '0;
         wcnt_d    = '0;
         carry_d   = '0;
         ip_id_d   = '0;
         pkt_d     = '0;
         cfg_err_d = 1'b0;
         tdata_d   = '0;
         tkeep_d   = '0;
         tvalid_d  = 1'b0;
         tlast_d   = 1'b0;
         s_ready   = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         hidx_q    <= '0;
         wcnt_q    <= '0;
         carry_q   <= '0;
         ip_id_q   <= '0;
         dmac_q    <= '0;
         smac_q    <= '0;
         sip_q     <= '0;
         dip_q     <= '0;
         sport_q   <= '0;
         dport_q   <= '0;
         plen_q    <= '0;
         csum_q    <= '0;
         pkt_q     <= '0;
         cfg_err_q <= 1'b0;
         tdata_q   <= '0;
         tkeep_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
`ifdef UDP_TX_IP_CSUM_EN
         sum_q     <= '0;
         calc_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         hidx_q    <= hidx_d;
         wcnt_q    <= wcnt_d;
         carry_q   <= carry_d;
         ip_id_q   <= ip_id_d;
         dmac_q    <= dmac_d;
         smac_q    <= smac_d;
         sip_q     <= sip_d;
         dip_q     <= dip_d;
         sport_q   <= sport_d;
         dport_q   <= dport_d;
         plen_q    <= plen_d;
         csum_q    <= csum_d;
         pkt_q     <= pkt_d;
         cfg_err_q <= cfg_err_d;
         tdata_q   <= tdata_d;
         tkeep_q   <= tkeep_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
`ifdef UDP_TX_IP_CSUM_EN
         sum_q     <= sum_d;
         calc_q    <= calc_d;
`endif
      end
   end

   assign s_tready  = s_ready;
   assign m_tdata   = tdata_q;
   assign m_tkeep   = tkeep_q;
   assign m_tvalid  = tvalid_q;
   assign m_tlast   = tlast_q;
   assign cfg_err   = cfg_err_q;
   assign pkt_count = pkt_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: directed tests for udp_tx_framer.
// Expected beats are hand-derived wire-order constants.
module tb_udp_tx_framer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tx_rst;
   logic [47:0] fpga_mac_adr, host_mac_adr;
   logic [31:0] fpga_ip_adr, host_ip_adr;
   logic [15:0] fpga_udp_port, host_udp_port;
   logic [15:0] payload_per_packet, checksum_ip;
   logic [63:0] s_tdata;
   logic        s_tvalid, s_tready;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tvalid, m_tready, m_tlast, cfg_err;
   logic [31:0] pkt_count;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   logic [63:0] words[$];
   logic [63:0] cap_d[$];
   logic [7:0]  cap_k[$];
   bit          cap_l[$];

   localparam logic [63:0] B0     = 64'h0B0A_5544_3322_1100;
   localparam logic [63:0] B1     = 64'h0045_0008_0F0E_0D0C;
   localparam logic [63:0] B2_ID0 = 64'h1140_0040_0000_2C00;
   localparam logic [63:0] B2_ID1 = 64'h1140_0040_0100_2C00;
`ifdef UDP_TX_IP_CSUM_EN
   localparam logic [63:0] B3_ID0 = 64'hA8C0_0100_A8C0_A8B8;
   localparam logic [63:0] B3_ID1 = 64'hA8C0_0100_A8C0_A7B8;
   localparam int          LAT    = 3;
`else
   localparam logic [63:0] B3_ID0 = 64'hA8C0_0100_A8C0_EFBE;
   localparam logic [63:0] B3_ID1 = 64'hA8C0_0100_A8C0_EFBE;
   localparam int          LAT    = 1;
`endif
   localparam logic [63:0] B4     = 64'h1800_7856_3412_C700;
   localparam logic [63:0] B5     = 64'h0504_0302_0100_0000;
   localparam logic [63:0] B6     = 64'h0D0C_0B0A_0908_0706;
   localparam logic [63:0] B7     = 64'h0000_0000_0000_0F0E;

   udp_tx_framer dut (
      .clk(clk), .reset_n(reset_n), .tx_rst(tx_rst),
      .fpga_mac_adr(fpga_mac_adr), .host_mac_adr(host_mac_adr),
      .fpga_ip_adr(fpga_ip_adr), .host_ip_adr(host_ip_adr),
      .fpga_udp_port(fpga_udp_port), .host_udp_port(host_udp_port),
      .payload_per_packet(payload_per_packet), .checksum_ip(checksum_ip),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tlast(m_tlast), .cfg_err(cfg_err),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Feeds words[] and captures accepted output beats until m_tlast
   task automatic run_frame(input logic [15:0] ppp, input bit stall,
                            input int max_cyc, output bit tmo);
      int wi, cyc;
      bit done, pv, pr, hs_m, hs_s;
      logic [63:0] pd;
      wi = 0; cyc = 0; done = 0; pv = 0; pr = 0; pd = '0; lat = -1;
      cap_d.delete(); cap_k.delete(); cap_l.delete();
      @(posedge clk); #1;
      payload_per_packet = ppp;
      s_tdata  = words[0];
      s_tvalid = 1'b1;
      m_tready = !stall;
      while (!done && cyc < max_cyc) begin
         @(negedge clk);
         if (stall && pv && !pr) begin
            n_tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== pd) begin
               n_fail++;
               $display("FAIL hold_stable: valid=%b data=%h required 1 %h",
                        m_tvalid, m_tdata, pd);
            end
         end
         if (m_tvalid && lat < 0) lat = cyc;
         hs_m = m_tvalid && m_tready;
         hs_s = s_tvalid && s_tready;
         if (hs_m) begin
            cap_d.push_back(m_tdata);
            cap_k.push_back(m_tkeep);
            cap_l.push_back(m_tlast);
            if (m_tlast) done = 1;
         end
         pv = m_tvalid; pr = m_tready; pd = m_tdata;
         @(posedge clk); #1;
         cyc++;
         if (hs_s) wi++;
         if (done) begin
            s_tvalid = 1'b0;
            m_tready = 1'b1;
         end else begin
            s_tvalid = (wi < words.size()) && !(stall && (cyc % 3 == 0));
            if (wi < words.size()) s_tdata = words[wi];
            m_tready = stall ? cyc[0] : 1'b1;
         end
      end
      tmo = !done;
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_tests++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tkeep !== 8'h00 ||
          m_tdata !== 64'h0 || s_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: v=%b l=%b k=%h d=%h r=%b required all 0",
                  m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready);
      end
      n_tests++;
      if (cfg_err !== 1'b0 || pkt_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_status: cfg_err=%b pkt=%0d required 0 0",
                  cfg_err, pkt_count);
      end
   endtask

   task automatic check_small_frame(input string nm, input logic [63:0] b2,
                                    input logic [63:0] b3, input int pkts);
      logic [63:0] exp_d[8];
      exp_d = '{B0, B1, b2, b3, B4, B5, B6, B7};
      n_tests++;
      if (cap_d.size() != 8) begin
         n_fail++;
         $display("FAIL %s_beats: got %0d required 8", nm, cap_d.size());
      end
      for (int i = 0; i < 8; i++) begin
         if (i < cap_d.size()) begin
            n_tests++;
            if (cap_d[i] !== exp_d[i] ||
                cap_k[i] !== ((i == 7) ? 8'h03 : 8'hFF) ||
                cap_l[i] !== (i == 7)) begin
               n_fail++;
               $display("FAIL %s_b%0d: d=%h k=%h l=%b required %h %h %b",
                        nm, i, cap_d[i], cap_k[i], cap_l[i], exp_d[i],
                        (i == 7) ? 8'h03 : 8'hFF, i == 7);
            end
         end
      end
      n_tests++;
      if (pkt_count !== 32'(pkts)) begin
         n_fail++;
         $display("FAIL %s_pkt: got %0d required %0d", nm, pkt_count, pkts);
      end
   endtask

   task automatic test_basic;
      bit tmo;
      words = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
      run_frame(16'd16, 1'b0, 100, tmo);
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL basic_timeout: no m_tlast"); end
      n_tests++;
      if (lat != LAT) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d required %0d", lat, LAT);
      end
      @(negedge clk);
      check_small_frame("basic", B2_ID0, B3_ID0, 1);
   endtask

   task automatic test_backpressure;
      bit tmo;
      words = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
      run_frame(16'd16, 1'b1, 200, tmo);
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL bp_timeout: no m_tlast"); end
      @(negedge clk);
      check_small_frame("bp", B2_ID1, B3_ID1, 2);
   endtask

   task automatic test_header;
      bit tmo;
      words.delete();
      for (int i = 0; i < 184; i++)
         words.push_back({16'h0100 + 16'(i), 16'h0000, 32'(i)});
      run_frame(16'd1472, 1'b0, 400, tmo);
      n_tests++;
      if (tmo || cap_d.size() != 190) begin
         n_fail++;
         $display("FAIL hdr_beats: got %0d required 190", cap_d.size());
      end else begin
         n_tests++;
         if (cap_d[2] !== 64'h1140_0040_0200_DC05) begin
            n_fail++;
            $display("FAIL hdr_b2: got %h required %h", cap_d[2],
                     64'h1140_0040_0200_DC05);
         end
         n_tests++;
         if (cap_d[4] !== 64'hC805_7856_3412_C700) begin
            n_fail++;
            $display("FAIL hdr_b4: got %h required %h", cap_d[4],
                     64'hC805_7856_3412_C700);
         end
         n_tests++;
         if (cap_d[6] !== 64'h0000_0000_0001_0100) begin
            n_fail++;
            $display("FAIL hdr_b6: got %h required %h", cap_d[6],
                     64'h0000_0000_0001_0100);
         end
         n_tests++;
         if (cap_d[189] !== 64'h01B7 || cap_k[189] !== 8'h03 ||
             cap_l[189] !== 1'b1 || cap_l[188] !== 1'b0) begin
            n_fail++;
            $display("FAIL hdr_tail: d=%h k=%h l=%b required 01b7 03 1",
                     cap_d[189], cap_k[189], cap_l[189]);
         end
      end
      @(negedge clk);
      n_tests++;
      if (pkt_count !== 32'd3) begin
         n_fail++;
         $display("FAIL hdr_pkt: got %0d required 3", pkt_count);
      end
   endtask

   task automatic test_reset_mid;
      int wi, nb;
      bit hit, hs_m, hs_s, tmo;
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back({8{8'(i + 8'h30)}});
      wi = 0; nb = 0; hit = 0;
      @(posedge clk); #1;
      payload_per_packet = 16'd64;
      s_tvalid = 1'b1; s_tdata = words[0]; m_tready = 1'b1;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(negedge clk);
         if (m_tvalid && nb == 7) begin
            hit = 1;
         end else begin
            hs_m = m_tvalid && m_tready;
            hs_s = s_tvalid && s_tready;
            if (hs_m) nb++;
            @(posedge clk); #1;
            if (hs_s) wi++;
            s_tvalid = (wi < 8);
            s_tdata  = words[(wi < 8) ? wi : 7];
         end
      end
      n_tests++;
      if (!hit) begin n_fail++; $display("FAIL rstmid_reach_b7: timeout"); end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_abort: v=%b l=%b r=%b required 0 0 0",
                  m_tvalid, m_tlast, s_tready);
      end
      s_tvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      words = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
      run_frame(16'd16, 1'b0, 100, tmo);
      n_tests++;
      if (tmo) begin n_fail++; $display("FAIL rstmid_timeout: no m_tlast"); end
      @(negedge clk);
      check_small_frame("rstmid", B2_ID0, B3_ID0, 1);
   endtask

   task automatic test_bad_cfg;
      logic [15:0] bad[3];
      bit seen;
      bad = '{16'd12, 16'd0, 16'd1480};
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         payload_per_packet = bad[j];
         s_tdata = 64'h1234;
         s_tvalid = 1'b1;
         seen = 0;
         repeat (6) begin
            @(negedge clk);
            if (m_tvalid || s_tready) seen = 1;
         end
         n_tests++;
         if (seen) begin
            n_fail++;
            $display("FAIL badcfg_%0d_quiet: frame activity seen", bad[j]);
         end
         n_tests++;
         if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL badcfg_%0d_err: got %b required 1", bad[j], cfg_err);
         end
         @(posedge clk); #1;
         s_tvalid = 1'b0;
         payload_per_packet = 16'd16;
         repeat (2) @(posedge clk);
         @(negedge clk);
         n_tests++;
         if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL badcfg_%0d_sticky: got %b required 1", bad[j], cfg_err);
         end
         @(posedge clk); #1;
         tx_rst = 1'b1;
         @(posedge clk); #1;
         tx_rst = 1'b0;
         @(negedge clk);
         n_tests++;
         if (cfg_err !== 1'b0 || pkt_count !== 32'd0) begin
            n_fail++;
            $display("FAIL badcfg_%0d_txrst: err=%b pkt=%0d required 0 0",
                     bad[j], cfg_err, pkt_count);
         end
      end
   endtask

`ifdef UDP_TX_IP_CSUM_EN
   task automatic test_csum;
      bit tmo;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      words.delete();
      for (int i = 0; i < 184; i++) words.push_back(64'(i));
      run_frame(16'd1472, 1'b0, 400, tmo);
      n_tests++;
      if (tmo || cap_d.size() < 4) begin
         n_fail++;
         $display("FAIL csum_frame: beats=%0d", cap_d.size());
      end else begin
         n_tests++;
         if (cap_d[3] !== 64'hA8C0_0100_A8C0_F8B2) begin
            n_fail++;
            $display("FAIL csum_b3: got %h required %h", cap_d[3],
                     64'hA8C0_0100_A8C0_F8B2);
         end
      end
      n_tests++;
      if (lat != 3) begin
         n_fail++;
         $display("FAIL csum_latency: got %0d required 3", lat);
      end
   endtask
`endif

   initial begin
      reset_n  = 1'b0;
      tx_rst   = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b1;
      host_mac_adr  = 48'h0011_2233_4455;
      fpga_mac_adr  = 48'h0A0B_0C0D_0E0F;
      fpga_ip_adr   = 32'hC0A8_0001;
      host_ip_adr   = 32'hC0A8_00C7;
      fpga_udp_port = 16'h1234;
      host_udp_port = 16'h5678;
      checksum_ip   = 16'hBEEF;
      payload_per_packet = 16'd16;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_header();
      test_reset_mid();
      test_bad_cfg();
`ifdef UDP_TX_IP_CSUM_EN
      test_csum();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
